if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 130 +++++++++++++
 tb/tb_if_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch with a one-entry skid buffer and
// redirect handling for a single outstanding imem read.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [5:0]  instr_op,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FULL,
        DRAIN
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc_plus4;
    logic        load;
    logic [31:0] pc_inc;
    logic [31:0] tgt;

    assign load     = !stall || !if_valid;
    assign pc_inc   = pc + 32'd4;
    assign tgt      = branch_target & 32'hFFFF_FFFC;
    assign instr_op = if_instr[31:26];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            imem_req      <= 1'b0;
            imem_addr     <= RESET_PC;
            if_instr      <= '0;
            if_pc_plus4   <= '0;
            if_valid      <= 1'b0;
            skid_instr    <= '0;
            skid_pc_plus4 <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (branch_taken) begin
                        pc        <= tgt;
                        imem_addr <= tgt;
                    end else begin
                        imem_addr <= pc;
                    end
                end

                FETCH: begin
                    if (branch_taken) begin
                        pc            <= tgt;
                        if_valid      <= 1'b0;
                        if_instr      <= '0;
                        skid_instr    <= '0;
                        skid_pc_plus4 <= '0;
                        // Without an ack the old read is still in flight;
                        // keep its address on the bus until it returns.
                        if (imem_ack) begin
                            imem_addr <= tgt;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc        <= pc_inc;
                        imem_addr <= pc_inc;
                        if (load) begin
                            if_instr    <= imem_rdata;
                            if_pc_plus4 <= pc_inc;
                            if_valid    <= 1'b1;
                        end else begin
                            skid_instr    <= imem_rdata;
                            skid_pc_plus4 <= pc_inc;
                            state         <= FULL;
                            imem_req      <= 1'b0;
                        end
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                        if_instr <= '0;
                    end
                end

                FULL: begin
                    if (branch_taken) begin
                        pc            <= tgt;
                        imem_addr     <= tgt;
                        imem_req      <= 1'b1;
                        state         <= FETCH;
                        if_valid      <= 1'b0;
                        if_instr      <= '0;
                        skid_instr    <= '0;
                        skid_pc_plus4 <= '0;
                    end else if (load) begin
                        if_instr    <= skid_instr;
                        if_pc_plus4 <= skid_pc_plus4;
                        if_valid    <= 1'b1;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end

                DRAIN: begin
                    if (branch_taken) begin
                        pc <= tgt;
                    end
                    if (imem_ack) begin
                        state     <= FETCH;
                        imem_addr <= branch_taken ? tgt : pc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed table for the fetch corner cases plus a
// randomized run against a two-entry queue model of the fetch stage.
module tb_if_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [5:0]  instr_op;
    logic [31:0] if_pc_plus4;
    logic        if_valid;

    logic        d2_req;
    logic [31:0] d2_addr;
    logic [31:0] d2_instr;
    logic [5:0]  d2_op;
    logic [31:0] d2_pc4;
    logic        d2_valid;

    if_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_instr     (if_instr),
        .instr_op     (instr_op),
        .if_pc_plus4  (if_pc_plus4),
        .if_valid     (if_valid)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (1'b0),
        .branch_taken (1'b0),
        .branch_target(32'h0),
        .imem_req     (d2_req),
        .imem_addr    (d2_addr),
        .imem_ack     (1'b1),
        .imem_rdata   (32'h0),
        .if_instr     (d2_instr),
        .instr_op     (d2_op),
        .if_pc_plus4  (d2_pc4),
        .if_valid     (d2_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        s;
        logic        b;
        logic [31:0] t;
        logic        a;
        logic        er;
        logic [31:0] ea;
        logic        ev;
        logic [31:0] ia;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic b,
                                input logic [31:0] t, input logic a,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ia);
        vec_t r;
        r.s = s; r.b = b; r.t = t; r.a = a;
        r.er = er; r.ea = ea; r.ev = ev; r.ia = ia;
        return r;
    endfunction

    typedef struct {
        logic [31:0] w;
        logic [31:0] p4;
    } ent_t;

    ent_t        q[$];
    logic        started;
    logic        draining;
    logic [31:0] npc;
    logic [31:0] daddr;

    function automatic logic m_req();
        return started && (draining || q.size() < 2);
    endfunction

    function automatic logic [31:0] m_addr();
        return draining ? daddr : npc;
    endfunction

    task automatic m_step(input logic s, input logic b,
                          input logic [31:0] t, input logic a);
        logic req;
        ent_t e;
        req = m_req();
        if (!started) begin
            started = 1'b1;
            if (b) npc = t & 32'hFFFF_FFFC;
        end else if (b) begin
            q.delete();
            if (draining) begin
                if (a) draining = 1'b0;
            end else if (req && !a) begin
                draining = 1'b1;
                daddr    = npc;
            end
            npc = t & 32'hFFFF_FFFC;
        end else if (draining) begin
            if (a) draining = 1'b0;
        end else begin
            if (!s && q.size() > 0) void'(q.pop_front());
            if (req && a) begin
                e.w  = word(npc);
                e.p4 = npc + 32'd4;
                q.push_back(e);
                npc = npc + 32'd4;
            end
        end
    endtask

    logic [31:0] cur_addr;
    logic [31:0] exp_instr;
    logic        rs, rb, ra;
    logic [31:0] rt;

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        imem_ack = 1'b0;
        imem_rdata = '0;

        tbl.push_back(mk(0, 0, 0,      0, 1, 32'h000, 0, 0));
        tbl.push_back(mk(0, 0, 0,      1, 1, 32'h004, 1, 32'h000));
        tbl.push_back(mk(0, 0, 0,      1, 1, 32'h008, 1, 32'h004));
        tbl.push_back(mk(0, 0, 0,      1, 1, 32'h00C, 1, 32'h008));
        tbl.push_back(mk(0, 0, 0,      1, 1, 32'h010, 1, 32'h00C));
        tbl.push_back(mk(1, 0, 0,      1, 0, 32'h000, 1, 32'h00C));
        tbl.push_back(mk(1, 0, 0,      0, 0, 32'h000, 1, 32'h00C));
        tbl.push_back(mk(0, 0, 0,      0, 1, 32'h014, 1, 32'h010));
        tbl.push_back(mk(0, 0, 0,      0, 1, 32'h014, 0, 0));
        tbl.push_back(mk(0, 0, 0,      1, 1, 32'h018, 1, 32'h014));
        tbl.push_back(mk(0, 0, 0,      1, 1, 32'h01C, 1, 32'h018));
        tbl.push_back(mk(0, 0, 0,      1, 1, 32'h020, 1, 32'h01C));
        tbl.push_back(mk(0, 1, 32'h103, 0, 1, 32'h020, 0, 0));
        tbl.push_back(mk(0, 0, 0,      0, 1, 32'h020, 0, 0));
        tbl.push_back(mk(0, 0, 0,      1, 1, 32'h100, 0, 0));
        tbl.push_back(mk(0, 0, 0,      1, 1, 32'h104, 1, 32'h100));
        tbl.push_back(mk(1, 1, 32'h200, 1, 1, 32'h200, 0, 0));
        tbl.push_back(mk(1, 0, 0,      1, 1, 32'h204, 1, 32'h200));
        tbl.push_back(mk(1, 0, 0,      1, 0, 32'h000, 1, 32'h200));
        tbl.push_back(mk(1, 1, 32'h300, 0, 1, 32'h300, 0, 0));
        tbl.push_back(mk(0, 0, 0,      1, 1, 32'h304, 1, 32'h300));
        tbl.push_back(mk(0, 1, 32'h400, 0, 1, 32'h304, 0, 0));
        tbl.push_back(mk(0, 1, 32'h500, 0, 1, 32'h304, 0, 0));
        tbl.push_back(mk(0, 0, 0,      1, 1, 32'h500, 0, 0));
        tbl.push_back(mk(0, 0, 0,      1, 1, 32'h504, 1, 32'h500));

        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_op", instr_op, 0);
        chk("rst_pc4", if_pc_plus4, 0);
        rst_n = 1'b1;

        cur_addr = 32'h0;
        for (int i = 0; i < tbl.size(); i++) begin
            stall         = tbl[i].s;
            branch_taken  = tbl[i].b;
            branch_target = tbl[i].t;
            imem_ack      = tbl[i].a;
            imem_rdata    = word(cur_addr);
            @(posedge clk);
            #1;
            exp_instr = tbl[i].ev ? word(tbl[i].ia) : 32'h0;
            chk($sformatf("t%0d_req", i), imem_req, tbl[i].er);
            if (tbl[i].er) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].ea);
            chk($sformatf("t%0d_valid", i), if_valid, tbl[i].ev);
            chk($sformatf("t%0d_instr", i), if_instr, exp_instr);
            chk($sformatf("t%0d_op", i), instr_op, exp_instr[31:26]);
            if (tbl[i].ev) chk($sformatf("t%0d_pc4", i), if_pc_plus4, tbl[i].ia + 32'd4);
            if (tbl[i].er) cur_addr = tbl[i].ea;
            if (i == 0) begin
                chk("wrap_req0", d2_req, 1);
                chk("wrap_addr0", d2_addr, 32'hFFFF_FFFC);
            end
            if (i == 1) begin
                chk("wrap_addr1", d2_addr, 32'h0);
                chk("wrap_pc4", d2_pc4, 32'h0);
                chk("wrap_valid", d2_valid, 1);
            end
        end

        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", imem_req, 0);
        chk("arst_valid", if_valid, 0);
        chk("arst_instr", if_instr, 0);
        chk("arst_pc4", if_pc_plus4, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        started  = 1'b0;
        draining = 1'b0;
        npc      = 32'h0;
        daddr    = 32'h0;
        stall = 1'b0;
        branch_taken = 1'b0;
        imem_ack = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(9) < 3);
            rb = (i > 0) && ($urandom_range(99) < 8);
            rt = ($urandom_range(3) == 0) ?
                 (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            ra = m_req() && ($urandom_range(9) < 6);
            stall         = rs;
            branch_taken  = rb;
            branch_target = rt;
            imem_ack      = ra;
            imem_rdata    = word(m_addr());
            @(posedge clk);
            #1;
            m_step(rs, rb, rt, ra);
            exp_instr = (q.size() > 0) ? q[0].w : 32'h0;
            chk("r_req", imem_req, m_req());
            if (m_req()) chk("r_addr", imem_addr, m_addr());
            chk("r_valid", if_valid, q.size() > 0);
            chk("r_instr", if_instr, exp_instr);
            chk("r_op", instr_op, exp_instr[31:26]);
            if (q.size() > 0) chk("r_pc4", if_pc_plus4, q[0].p4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
